// File: rtl/rom_fetch_bridge.sv
// rom_fetch_bridge
//   Follows the CPU instruction-cycle phases (A1..X3). It collects the
//   12-bit fetch address from the CPU bus during A1..A3. If CM-ROM was
//   selected in A3, it fetches one byte from an external byte memory. The
//   byte goes back to the CPU as the high nibble in M1 and the low nibble
//   in M2.
//
// Ports
//   sysclk    in   system clock, all logic on rising edge
//   poc       in   asynchronous active-high reset
//   clk2      in   CPU phase-2 strobe (sysclk-synchronous)
//   sync      in   CPU SYNC, marks the step into A1
//   cmrom     in   CM-ROM select, sampled at the step leaving A3
//   data_out  in   [3:0] CPU bus nibble (address source)
//   rom_data  out  [3:0] nibble returned to the CPU
//   rom_oe    out  rom_data is driven
//   mem_req   out  byte-memory request
//   mem_addr  out  [11:0] byte-memory address
//   mem_ack   in   byte-memory acknowledge
//   mem_data  in   [7:0] byte-memory data
//   phase     out  [2:0] current phase (A1=0 .. X3=7, 7 while unlocked)
//   locked    out  phase tracker synchronised
//   late_err  out  one-cycle pulse: memory missed the M1 deadline
//   sync_err  out  one-cycle pulse: SYNC seen out of place
//
// Handshake: the memory transfer takes place in the sysclk cycle where
// mem_req and mem_ack are both 1. The bridge then lowers mem_req on the
// next cycle. mem_ack is ignored while mem_req is 0. mem_addr is stable
// while mem_req is 1.
module rom_fetch_bridge (
   input  logic        sysclk,
   input  logic        poc,
   input  logic        clk2,
   input  logic        sync,
   input  logic        cmrom,
   input  logic [3:0]  data_out,
   output logic [3:0]  rom_data,
   output logic        rom_oe,
   output logic        mem_req,
   output logic [11:0] mem_addr,
   input  logic        mem_ack,
   input  logic [7:0]  mem_data,
   output logic [2:0]  phase,
   output logic        locked,
   output logic        late_err,
   output logic        sync_err
);

   typedef enum logic [3:0] {
      ST_A1   = 4'd0,
      ST_A2   = 4'd1,
      ST_A3   = 4'd2,
      ST_M1   = 4'd3,
      ST_M2   = 4'd4,
      ST_X1   = 4'd5,
      ST_X2   = 4'd6,
      ST_X3   = 4'd7,
      ST_IDLE = 4'd8
   } state_t;

   state_t      state, state_n;
   logic        clk2_q;
   logic        step;
   logic        resync;
   logic        deadline;
   logic        selected;
   logic [11:0] addr_q;
   logic [7:0]  byte_q;

   // A step is a falling edge of clk2 seen through one register. clk2_q
   // resets to 0, so an edge in the first cycle after reset is not a step.
   assign step = clk2_q & ~clk2;

   // ---------------- state register ----------------
   always_ff @(posedge sysclk or posedge poc) begin
      if (poc) begin
         state  <= ST_IDLE;
         clk2_q <= 1'b0;
      end else begin
         state  <= state_n;
         clk2_q <= clk2;
      end
   end

   // ---------------- next-state logic ----------------
   // resync marks every out-of-place SYNC event. It aborts the current
   // fetch and raises sync_err.
   always_comb begin
      state_n = state;
      resync  = 1'b0;
      if (step) begin
         if (sync) begin
            state_n = ST_A1;
            resync  = (state != ST_X3) && (state != ST_IDLE);
         end else if (state == ST_X3) begin
            state_n = ST_IDLE;
            resync  = 1'b1;
         end else if (state != ST_IDLE) begin
            state_n = state_t'(state + 4'd1);
         end
      end
   end

   // The step that ends M1 is the latest point for the memory. An ack in
   // that same cycle is still late. A resync at that step is an abort,
   // not a late fetch.
   assign deadline = step && (state == ST_M1) && !resync;

   // ---------------- fetch datapath ----------------
   always_ff @(posedge sysclk or posedge poc) begin
      if (poc) begin
         addr_q   <= 12'h000;
         byte_q   <= 8'h00;
         selected <= 1'b0;
         mem_req  <= 1'b0;
         late_err <= 1'b0;
         sync_err <= 1'b0;
      end else begin
         late_err <= 1'b0;
         sync_err <= resync;

         if (step) begin
            case (state)
               ST_A1:   addr_q[3:0]  <= data_out;
               ST_A2:   addr_q[7:4]  <= data_out;
               ST_A3:   addr_q[11:8] <= data_out;
               default: ;
            endcase
         end

         if (resync) begin
            mem_req  <= 1'b0;
            selected <= 1'b0;
         end else if (deadline && mem_req) begin
            late_err <= 1'b1;
            mem_req  <= 1'b0;
            byte_q   <= 8'h00;
         end else if (step && (state == ST_A3)) begin
            // Clear the byte so nothing stale from the last fetch reaches M1.
            selected <= cmrom;
            mem_req  <= cmrom;
            byte_q   <= 8'h00;
         end else if (mem_req && mem_ack) begin
            byte_q  <= mem_data;
            mem_req <= 1'b0;
         end
      end
   end

   // addr_q only changes at A1..A3 steps. mem_req is always 0 then, so
   // the address is stable for the whole request.
   assign mem_addr = addr_q;

   // ---------------- outputs ----------------
   always_comb begin
      locked   = (state != ST_IDLE);
      phase    = locked ? state[2:0] : 3'd7;
      rom_oe   = selected && ((state == ST_M1) || (state == ST_M2));
      rom_data = 4'h0;
      if (rom_oe) begin
         rom_data = (state == ST_M1) ? byte_q[7:4] : byte_q[3:0];
      end
   end

endmodule

// File: doc/rom_fetch_bridge.md
ROM_FETCH_BRIDGE -- requirements
Module: rom_fetch_bridge

Interface
REQ-001 SHALL have ports: sysclk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: poc  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: clk2  in  1  CPU phase-2 strobe, synchronous to sysclk.
REQ-004 SHALL have: sync  in  1  CPU SYNC, active-high, synchronous to sysclk.
REQ-005 SHALL have: cmrom  in  1  CPU CM-ROM select, active-high.
REQ-006 SHALL have: data_out  in  4  CPU-driven bus nibble (address source).
REQ-007 SHALL have: rom_data  out  4  nibble returned to CPU data input.
REQ-008 SHALL have: rom_oe  out  1  rom_data valid/driven.
REQ-009 SHALL have: mem_req  out  1, mem_addr  out  12, mem_ack  in  1, mem_data  in  8  external byte-memory handshake.
REQ-010 SHALL have: phase  out  3  current phase (A1=0,A2=1,A3=2,M1=3,M2=4,X1=5,X2=6,X3=7); locked  out  1  phase tracker synchronised.
REQ-011 SHALL have: late_err  out  1  and  sync_err  out  1, single-sysclk pulses.

Function
REQ-012 Phase step SHALL be the sysclk cycle where registered clk2 is 1 and current clk2 is 0; all phase logic acts only on phase steps.
REQ-013 Tracker SHALL have states IDLE (locked=0, phase=7) and A1..X3 (locked=1); non-step cycles hold state.
REQ-014 At a step with sync=1: from X3 or IDLE -> A1 silently; from any other state -> A1 with sync_err pulse.
REQ-015 At a step with sync=0: from X3 -> IDLE with sync_err pulse; from IDLE stay IDLE; otherwise advance A1->A2->...->X3.
REQ-016 At step leaving A1/A2/A3, address register SHALL capture data_out into bits [3:0]/[7:4]/[11:8] respectively.
REQ-017 At step leaving A3, selected flag SHALL capture cmrom; if 1, mem_req SHALL assert next sysclk with mem_addr = 12-bit captured address; if 0, no request and no drive this cycle.
REQ-018 Handshake: transfer occurs in the sysclk where mem_req=1 and mem_ack=1; byte latched from mem_data, mem_req deasserts next cycle; mem_ack while mem_req=0 SHALL be ignored.
REQ-019 mem_addr SHALL hold stable while mem_req=1.
REQ-020 Deadline: if no transfer has occurred before the step ending M1 (ack coincident with that step counts late), late_err SHALL pulse, mem_req SHALL drop next cycle, latched byte SHALL be forced 8'h00.
REQ-021 When selected: rom_oe=1 throughout M1 and M2; rom_data = byte[7:4] in M1, byte[3:0] in M2; before transfer in M1, rom_data=4'h0.
REQ-022 rom_oe SHALL be 0 in all other phases, in IDLE, and when not selected; rom_data SHALL be 4'h0 whenever rom_oe=0.
REQ-023 A resync (REQ-014/015) SHALL abort any outstanding request (mem_req=0 next cycle) and clear selected flag; no late_err for aborted fetch.
REQ-024 Simultaneous phase step and transfer outside the M1-ending step SHALL both take effect.

Reset
REQ-025 poc=1 SHALL asynchronously force: state IDLE, phase=7, locked=0, mem_req=0, mem_addr=0, address/byte registers 0, selected=0, rom_oe=0, rom_data=0, late_err=0, sync_err=0, registered clk2=0.
REQ-026 Reset asserted mid-fetch SHALL drop mem_req immediately; after release, no output changes until first step with sync=1.
REQ-027 A clk2 falling edge in the first sysclk after poc release SHALL NOT count as a step.

Verification
REQ-028 Normal fetch: SYNC at X3, A1..A3 data_out=4'h5,4'hA,4'h3, cmrom=1 in A3, ack 2 cycles later with 8'hD4 -> mem_addr=12'h3A5, rom_data=4'hD in M1, 4'h4 in M2, rom_oe=1 only M1/M2.
REQ-029 Deselected: same sequence with cmrom=0 -> mem_req never asserts, rom_oe=0 all cycle.
REQ-030 Late ack: ack withheld past M1-ending step -> late_err one pulse, rom_data=4'h0 in M1 and M2, mem_req=0 afterwards.
REQ-031 Sync faults: sync=1 at step in M2 -> sync_err pulse, phase=0 (A1), outstanding mem_req dropped; sync=0 at X3 step -> sync_err pulse, locked=0.
REQ-032 Reset mid-M1 with mem_req=1 -> all outputs zero immediately, locked=0, phase=7; relock on next sync step.
REQ-033 Back-to-back instruction cycles with addresses 12'hFFF then 12'h000 -> correct mem_addr each cycle, no stale byte carried over.
